// File: rtl/ball_pace_ctrl.sv
// rtl/ball_pace_ctrl.sv - serve delay and ball-step pacing over an external ripple counter
module ball_pace_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SERVE_DLY   = 200,
    parameter int BASE_PERIOD = 40,
    parameter int MIN_PERIOD  = 10,
    parameter int SPEEDUP     = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TICK,
    input  logic             START,
    input  logic             HIT,
    input  logic             MISS,
    input  logic [WIDTH-1:0] CNT_Q,
    output logic             CNT_EN,
    output logic             CNT_CLRN,
    output logic             STEP,
    output logic [WIDTH-1:0] PERIOD,
    output logic [1:0]       STATE,
    output logic             SERVING
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SERVE  = 2'b01,
        S_RUN    = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] SERVE_LIM = WIDTH'(SERVE_DLY);
    localparam logic [WIDTH-1:0] BASE      = WIDTH'(BASE_PERIOD);
    localparam logic [WIDTH-1:0] MINP      = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] SPD       = WIDTH'(SPEEDUP);
    // One extra bit so MIN_PERIOD+SPEEDUP cannot wrap in the saturation test
    localparam logic [WIDTH:0]   FLOOR     = (WIDTH+1)'(MIN_PERIOD) + (WIDTH+1)'(SPEEDUP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] limit, limit_m1, period_nxt;
    logic             active, term, clrn_nxt, step_nxt;

    always_comb begin
        active   = (state == S_SERVE) || (state == S_RUN);
        limit    = (state == S_SERVE) ? SERVE_LIM : PERIOD;
        limit_m1 = limit - WIDTH'(1);
        // >= rather than == so a PERIOD shrunk below the count still terminates
        term     = TICK && active && CNT_CLRN && (CNT_Q >= limit_m1);
        CNT_EN   = TICK && active && CNT_CLRN && !term;

        state_nxt = state;
        case (state)
            S_SERVE: begin
                if (MISS)      state_nxt = S_IDLE;
                else if (term) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (MISS) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = START ? S_SERVE : S_IDLE;
            end
        endcase

        clrn_nxt = (state_nxt != S_IDLE) && !term;
        step_nxt = (state == S_RUN) && term && !MISS;

        period_nxt = PERIOD;
        if (state_nxt == S_IDLE) begin
            period_nxt = BASE;
        end else if ((state == S_RUN) && HIT) begin
            period_nxt = ({1'b0, PERIOD} >= FLOOR) ? (PERIOD - SPD) : MINP;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            CNT_CLRN <= 1'b0;
            STEP     <= 1'b0;
            PERIOD   <= BASE;
        end else begin
            state    <= state_nxt;
            CNT_CLRN <= clrn_nxt;
            STEP     <= step_nxt;
            PERIOD   <= period_nxt;
        end
    end

    assign STATE   = state;
    assign SERVING = (state == S_SERVE);

endmodule

// File: tb/tb_ball_pace_ctrl.sv
// tb/tb_ball_pace_ctrl.sv - directed bench for ball_pace_ctrl with a modelled ripple counter
module tb_ball_pace_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TICK = 1'b0, START = 1'b0, HIT = 1'b0, MISS = 1'b0;
    logic [7:0] CNT_Q = 8'd0;
    logic       CNT_EN, CNT_CLRN, STEP, SERVING;
    logic [7:0] PERIOD;
    logic [1:0] STATE;

    int total = 0;
    int bad   = 0;
    int tick_num = 0, step_num = 0, last_step = 0, prev_step = 0;

    ball_pace_ctrl #(
        .WIDTH(8), .SERVE_DLY(5), .BASE_PERIOD(8), .MIN_PERIOD(4), .SPEEDUP(2)
    ) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .HIT(HIT), .MISS(MISS),
        .CNT_Q(CNT_Q), .CNT_EN(CNT_EN), .CNT_CLRN(CNT_CLRN), .STEP(STEP),
        .PERIOD(PERIOD), .STATE(STATE), .SERVING(SERVING)
    );

    always #5 CLK = ~CLK;

    // External chain: increments on CNT_EN, cleared asynchronously by CNT_CLRN
    always @(posedge CLK or negedge CNT_CLRN) begin
        if (!CNT_CLRN) CNT_Q <= 8'd0;
        else if (CNT_EN) CNT_Q <= CNT_Q + 8'd1;
    end

    always @(negedge CLK) begin
        if (TICK === 1'b1) tick_num++;
        if (STEP === 1'b1) begin
            step_num++;
            prev_step = last_step;
            last_step = tick_num;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_tick();
        TICK = 1'b1;
        clk1();
        TICK = 1'b0;
        clk1();
        clk1();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic serve();
        START = 1'b1;
        clk1();
        START = 1'b0;
        do_ticks(5);
    endtask

    int steps0;

    initial begin
        // Reset with random inputs
        RST = 1'b1;
        TICK = 1'($urandom); START = 1'($urandom); HIT = 1'($urandom); MISS = 1'($urandom);
        clk1();
        chk("rst_state", STATE, 2'b00);
        chk("rst_clrn", CNT_CLRN, 0);
        chk("rst_step", STEP, 0);
        chk("rst_period", PERIOD, 8);
        TICK = 1'b1; START = 1'($urandom); HIT = 1'($urandom); MISS = 1'($urandom);
        #1;
        chk("rst_cnt_en", CNT_EN, 0);
        clk1();
        chk("rst_state2", STATE, 2'b00);
        chk("rst_period2", PERIOD, 8);
        chk("rst_cnt_en2", CNT_EN, 0);
        RST = 1'b0; TICK = 1'b0; START = 1'b0; HIT = 1'b0; MISS = 1'b0;
        clk1();

        // Serve: exactly 5 counted ticks
        START = 1'b1;
        clk1();
        START = 1'b0;
        chk("serve_state", STATE, 2'b01);
        chk("serve_serving", SERVING, 1);
        chk("serve_clrn", CNT_CLRN, 1);
        do_ticks(4);
        chk("serve_state_4", STATE, 2'b01);
        chk("serve_cnt_4", CNT_Q, 4);
        TICK = 1'b1;
        clk1();
        TICK = 1'b0;
        chk("run_entry_state", STATE, 2'b10);
        chk("run_entry_clrn", CNT_CLRN, 0);
        chk("run_entry_step", STEP, 0);
        clk1();
        chk("run_clrn_back", CNT_CLRN, 1);
        chk("run_cnt_zero", CNT_Q, 0);
        clk1();

        // Run at base period 8
        steps0 = step_num;
        TICK = 1'b1;
        #1;
        chk("run_cnt_en", CNT_EN, 1);
        clk1();
        TICK = 1'b0;
        clk1(); clk1();
        do_ticks(6);
        chk("run_cnt_peak", CNT_Q, 7);
        chk("run_no_step_yet", step_num - steps0, 0);
        TICK = 1'b1;
        #1;
        chk("term_cnt_en", CNT_EN, 0);
        clk1();
        TICK = 1'b0;
        chk("run_step_hi", STEP, 1);
        chk("run_step_clrn", CNT_CLRN, 0);
        clk1();
        chk("run_step_lo", STEP, 0);
        clk1();
        do_ticks(8);
        chk("run_steps", step_num - steps0, 2);
        chk("run_interval8", last_step - prev_step, 8);

        // Speedup: 8 -> 6 -> 4 -> 4
        HIT = 1'b1; clk1(); HIT = 1'b0;
        chk("hit_period6", PERIOD, 6);
        do_ticks(6);
        chk("interval6", last_step - prev_step, 6);
        HIT = 1'b1; clk1(); HIT = 1'b0;
        chk("hit_period4", PERIOD, 4);
        HIT = 1'b1; clk1(); HIT = 1'b0;
        chk("hit_period_floor", PERIOD, 4);
        do_ticks(4);
        chk("interval4", last_step - prev_step, 4);

        // Miss in RUN restores base period
        MISS = 1'b1; clk1(); MISS = 1'b0;
        chk("miss_state", STATE, 2'b00);
        chk("miss_period", PERIOD, 8);
        chk("miss_clrn", CNT_CLRN, 0);

        // Shrink past count: CNT_Q=6, PERIOD 8 -> 6, next tick terminal
        serve();
        do_ticks(6);
        chk("shrink_cnt6", CNT_Q, 6);
        HIT = 1'b1; clk1(); HIT = 1'b0;
        chk("shrink_period", PERIOD, 6);
        chk("shrink_cnt_kept", CNT_Q, 6);
        steps0 = step_num;
        TICK = 1'b1; clk1(); TICK = 1'b0;
        chk("shrink_step", STEP, 1);
        chk("shrink_cnt_cleared", CNT_Q, 0);
        clk1(); clk1();
        chk("shrink_one_step", step_num - steps0, 1);

        // MISS coincident with terminal tick
        do_ticks(5);
        chk("misst_cnt5", CNT_Q, 5);
        steps0 = step_num;
        TICK = 1'b1; MISS = 1'b1; clk1(); TICK = 1'b0; MISS = 1'b0;
        chk("misst_state", STATE, 2'b00);
        chk("misst_clrn", CNT_CLRN, 0);
        chk("misst_period", PERIOD, 8);
        chk("misst_step", STEP, 0);
        clk1();
        chk("misst_no_step", step_num - steps0, 0);

        // HIT in SERVE ignored, START in RUN ignored, RST mid-RUN
        START = 1'b1; clk1(); START = 1'b0;
        HIT = 1'b1; clk1(); HIT = 1'b0;
        chk("serve_hit_ignored", PERIOD, 8);
        do_ticks(5);
        do_ticks(3);
        START = 1'b1; clk1(); START = 1'b0;
        chk("run_start_state", STATE, 2'b10);
        chk("run_start_cnt", CNT_Q, 3);
        steps0 = step_num;
        RST = 1'b1; clk1(); RST = 1'b0;
        chk("rstrun_state", STATE, 2'b00);
        chk("rstrun_clrn", CNT_CLRN, 0);
        chk("rstrun_cnt", CNT_Q, 0);
        chk("rstrun_step", STEP, 0);
        clk1();
        chk("rstrun_no_step", step_num - steps0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
